conv_mac: RTL
=============

// Module: conv_mac
// PURPOSE
//  Downstream consumer of the line-buffer window stage: takes one flattened KW x KH pixel window per valid cycle and
//  multiplies each element by a stored weight. Sums the products in a fully registered adder tree and adds a bias.
//  Emits one convolution result per accepted window. Weights and bias are loaded serially before streaming starts.
// PARAMETERS
//  dataWidth    1    pixel width (unsigned)
//  weightWidth  8    weight/bias width (signed, two's complement)
//  kernelWidth  5    window columns (KW)
//  kernelHeight 5    window rows (KH); N = KW*KH elements
//  Derived: LVL = clog2(N); OW = dataWidth+weightWidth+LVL+1; LAT = LVL+2
// PORTS
//  i_clk          in   1              clock, all logic on posedge
//  i_rst          in   1              synchronous active-high reset
//  i_window       in   N*dataWidth    element e = i_window[e*dataWidth +: dataWidth]
//  i_window_valid in   1              window present this cycle
//  i_wt_start     in   1              pulse: begin (re)load of weights
//  i_wt_data      in   weightWidth    serial weight/bias word
//  i_wt_valid     in   1              i_wt_data valid
//  o_wt_loaded    out  1              weights+bias complete, streaming enabled
//  o_drop         out  1              sticky: a window arrived while not in RUN
//  o_data         out  OW             signed convolution result
//  o_data_valid   out  1              o_data valid (1-cycle per result)
// BEHAVIOUR
//  Reset: state=IDLE, load counter=0, all weights/bias=0, valid pipe cleared; every output 0.
//  FSM: IDLE -(i_wt_start)-> LOAD -(bias word accepted)-> RUN -(i_wt_start)-> LOAD.
//  LOAD: each i_wt_valid stores word at index cnt (0..N-1 = weight e, N = bias); cnt++.
//  On cnt==N word: bias stored, next state RUN, o_wt_loaded=1 from next cycle.
//  i_wt_start in any state: cnt<=0, state LOAD, o_wt_loaded<=0, o_drop<=0, valid pipe flushed (in-flight results discarded).
//  i_wt_start and i_wt_valid same cycle: start wins, word discarded.
//  i_wt_valid outside LOAD: ignored. Weights hold their values until overwritten.
//  i_window_valid outside RUN: window ignored, o_drop<=1 (sticky until reset/i_wt_start).
//  RUN, no backpressure: every valid window accepted.
//   Stage 1 registers N products p[e] = $signed({1'b0,pix[e]}) * w[e].
//   Stages 2..LVL+1: pairwise registered add, odd element passed through, sign-extended one bit per level.
//   Stage LVL+2 registers sum + sign-extended bias.
//  Latency: o_data_valid exactly LAT cycles after accepted i_window_valid (LAT=7 for 5x5); back-to-back windows give back-to-back results.
//  o_data holds last value when o_data_valid=0. OW sized so no overflow is possible; no saturation.
//  Reset mid-stream: results in flight are lost; no o_data_valid until reload completes.
// CONFIGURATION
//  CONV_MAC_RELU_EN defined: final stage registers max(0, sum+bias); o_data never negative.
//  CONV_MAC_RELU_EN undefined: raw signed sum+bias. Latency is identical in both builds.
// STRUCTURE
//  Shared package conv_pkg: clog2 function, OW/LAT derivation, FSM state encoding (IDLE/LOAD/RUN).
//  Sub-module conv_add_tree_stage: one registered reduction level (M inputs -> ceil(M/2) outputs, width+1).
//  conv_mac generates LVL instances of conv_add_tree_stage.
//  Control, weight store, multiplier stage and bias/activation stage stay in conv_mac.
// TESTING
//  1. Load all 25 weights=1, bias=0; window all ones -> o_data=25 exactly 7 cycles after valid.
//  2. Weights e-12 (-12..12), bias=-3, window all ones -> 0-3 = -3, or 0 with CONV_MAC_RELU_EN.
//  3. 10 back-to-back windows with a single 1 at element k=0..9, weights=e -> results 0..9 on 10 consecutive cycles.
//  4. Window valid during LOAD -> no o_data_valid, o_drop=1; i_wt_start clears o_drop.
//  5. i_wt_start 3 cycles after a RUN window -> that result never appears; o_wt_loaded drops.
//     Reload then behaves per test 1.
//  6. i_rst asserted mid-stream -> all outputs 0 next cycle, windows ignored until full reload.
//     i_wt_start with i_wt_valid in same cycle -> word discarded, cnt=0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared helpers for the conv_mac datapath: width/latency derivation, adder-tree sizing
// and the control state encoding.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } conv_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Number of operands left after lvl pairwise reduction levels.
  function automatic int tree_count(input int n, input int lvl);
    int m;
    m = n;
    for (int i = 0; i < lvl; i++) m = (m + 1) / 2;
    return m;
  endfunction

  function automatic int calc_ow(input int dw, input int ww, input int n);
    return dw + ww + clog2(n) + 1;
  endfunction

  function automatic int calc_lat(input int n);
    return clog2(n) + 2;
  endfunction

endpackage

// File: rtl/conv_add_tree_stage.sv
// conv_add_tree_stage: one registered reduction level of the conv_mac adder tree.
// Signed input pairs are summed one bit wider; an odd trailing input is sign-extended through.
module conv_add_tree_stage #(
  parameter int M = 25,
  parameter int W = 10
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [M*W-1:0]                i_data,
  output logic [((M+1)/2)*(W+1)-1:0]    o_data
);

  localparam int OM = (M + 1) / 2;

  logic [OM*(W+1)-1:0] sum_c;

  for (genvar j = 0; j < OM; j++) begin : g_pair
    logic [W-1:0] a;
    assign a = i_data[2*j*W +: W];
    if (2*j + 1 < M) begin : g_add
      logic [W-1:0] b;
      assign b = i_data[(2*j+1)*W +: W];
      assign sum_c[j*(W+1) +: W+1] = {a[W-1], a} + {b[W-1], b};
    end else begin : g_pass
      assign sum_c[j*(W+1) +: W+1] = {a[W-1], a};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) o_data <= '0;
    else       o_data <= sum_c;
  end

endmodule

// File: rtl/conv_mac.sv
// conv_mac: windowed multiply-accumulate with serially loaded weights and bias.
// Build option CONV_MAC_RELU_EN clamps negative results to zero in the final stage.
//
// state   | meaning
// IDLE    | after reset, no weights loaded, windows dropped
// LOAD    | accepting serial weight words, then the bias word
// RUN     | weights valid, every presented window accepted
module conv_mac
  import conv_pkg::*;
#(
  parameter int dataWidth    = 1,
  parameter int weightWidth  = 8,
  parameter int kernelWidth  = 5,
  parameter int kernelHeight = 5
) (
  input  logic                                                     i_clk,
  input  logic                                                     i_rst,
  input  logic [kernelWidth*kernelHeight*dataWidth-1:0]            i_window,
  input  logic                                                     i_window_valid,
  input  logic                                                     i_wt_start,
  input  logic [weightWidth-1:0]                                   i_wt_data,
  input  logic                                                     i_wt_valid,
  output logic                                                     o_wt_loaded,
  output logic                                                     o_drop,
  output logic [dataWidth+weightWidth+clog2(kernelWidth*kernelHeight):0] o_data,
  output logic                                                     o_data_valid
);

  localparam int N   = kernelWidth * kernelHeight;
  localparam int LVL = clog2(N);
  localparam int PW  = dataWidth + weightWidth + 1;
  localparam int OW  = calc_ow(dataWidth, weightWidth, N);
  localparam int LAT = calc_lat(N);
  localparam int CW  = clog2(N + 1);
  localparam logic [CW-1:0] CNT_BIAS = CW'(N);

  conv_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr_en, accept, drop_d;
  logic signed [weightWidth-1:0] w_q [N];
  logic signed [weightWidth-1:0] bias_q;
  logic [LAT-2:0] vld_q;
  logic [N*PW-1:0] prod_q;
  logic [OW-1:0] tree_sum;
  logic signed [OW-1:0] sum_c;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      o_drop  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_drop  <= drop_d;
    end
  end

  // A start pulse overrides everything else in the same cycle, including a weight word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = o_drop;
    wr_en   = 1'b0;
    accept  = 1'b0;
    if (i_wt_start) begin
      state_d = ST_LOAD;
      cnt_d   = '0;
      drop_d  = 1'b0;
    end else begin
      if (i_window_valid) begin
        if (state_q == ST_RUN) accept = 1'b1;
        else                   drop_d = 1'b1;
      end
      if (state_q == ST_LOAD && i_wt_valid) begin
        wr_en = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_BIAS) state_d = ST_RUN;
      end
    end
  end

  assign o_wt_loaded = (state_q == ST_RUN);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int e = 0; e < N; e++) w_q[e] <= '0;
      bias_q <= '0;
    end else if (wr_en) begin
      if (cnt_q == CNT_BIAS) bias_q <= i_wt_data;
      else                   w_q[cnt_q] <= i_wt_data;
    end
  end

  function automatic logic signed [PW-1:0] mul(input logic [dataWidth-1:0] px,
                                               input logic signed [weightWidth-1:0] w);
    logic signed [PW-1:0] a, b;
    a = PW'({1'b0, px});
    b = PW'(w);
    return a * b;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) prod_q <= '0;
    else begin
      for (int e = 0; e < N; e++)
        prod_q[e*PW +: PW] <= mul(i_window[e*dataWidth +: dataWidth], w_q[e]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_wt_start) vld_q <= '0;
    else                     vld_q <= {vld_q[LAT-3:0], accept};
  end

  for (genvar g = 0; g < LVL; g++) begin : g_lvl
    localparam int MI = tree_count(N, g);
    localparam int WI = PW + g;
    logic [MI*WI-1:0] din;
    logic [tree_count(N, g+1)*(WI+1)-1:0] dout;
    if (g == 0) begin : g_first
      assign din = prod_q;
    end else begin : g_next
      assign din = g_lvl[g-1].dout;
    end
    conv_add_tree_stage #(.M(MI), .W(WI)) u_stage (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_data (din),
      .o_data (dout)
    );
  end

  assign tree_sum = g_lvl[LVL-1].dout;

  always_comb begin
    sum_c = $signed(tree_sum) + OW'(bias_q);
`ifdef CONV_MAC_RELU_EN
    if (sum_c[OW-1]) sum_c = '0;
`endif
  end

  // A flush in the same cycle discards the result about to emerge and keeps o_data as is.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data       <= '0;
      o_data_valid <= 1'b0;
    end else begin
      o_data_valid <= vld_q[LAT-2] && !i_wt_start;
      if (vld_q[LAT-2] && !i_wt_start) o_data <= sum_c;
    end
  end

endmodule
